// File: rtl/icache_refill_bridge.sv
// Instruction-cache line refill over an AXI read burst: one INCR burst per miss, line assembled
// in a local buffer and presented for a single cycle once rlast arrives.
module icache_refill_bridge #(
  parameter int offset_width = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               icache_mem_req,
  input  logic [31:0]                        icache_mem_addr,
  input  logic [1:0]                         icache_mem_size,
  output logic                               mem_icache_addrOK,
  output logic                               mem_icache_dataOK,
  output logic [32*(2**offset_width)-1:0]    mem_icache_data,
  output logic                               arvalid,
  input  logic                               arready,
  output logic [31:0]                        araddr,
  output logic [7:0]                         arlen,
  output logic [2:0]                         arsize,
  output logic [1:0]                         arburst,
  input  logic                               rvalid,
  output logic                               rready,
  input  logic [31:0]                        rdata,
  input  logic [1:0]                         rresp,
  input  logic                               rlast,
  output logic                               bridge_err
);

  localparam int N = 2 ** offset_width;
  localparam logic [offset_width-1:0] LAST_IDX = offset_width'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [31:0]             line_addr_q;
  logic [offset_width-1:0] cnt_q;
  logic                    wrapped_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    dataok_q;
  logic                    err_q;
  logic [31:0]             line_q [N];

  // Size code and in-line offset do not affect the burst; the whole line is always fetched.
  logic unused_bits;
  assign unused_bits = ^{icache_mem_size, icache_mem_addr[1+offset_width:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      line_addr_q <= '0;
      cnt_q       <= '0;
      wrapped_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      dataok_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      dataok_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (icache_mem_req) begin
            line_addr_q <= {icache_mem_addr[31:2+offset_width], {(2+offset_width){1'b0}}};
            arvalid_q   <= 1'b1;
            state_q     <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            line_q[cnt_q] <= rdata;
            cnt_q         <= cnt_q + offset_width'(1);
            if (cnt_q == LAST_IDX) begin
              wrapped_q <= 1'b1;
            end
            // Error response, a beat past the line end, or a short burst all flag the bus.
            if ((rresp != 2'b00) || wrapped_q || (rlast && (cnt_q != LAST_IDX))) begin
              err_q <= 1'b1;
            end
            if (rlast) begin
              rready_q <= 1'b0;
              dataok_q <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_icache_addrOK = rstn && (state_q == S_IDLE) && icache_mem_req;
  assign mem_icache_dataOK = dataok_q;
  assign arvalid           = arvalid_q;
  assign rready            = rready_q;
  assign bridge_err        = err_q;
  assign araddr            = line_addr_q;
  assign arlen             = 8'(N - 1);
  assign arsize            = 3'b010;
  assign arburst           = 2'b01;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mem_icache_data[32*i +: 32] = line_q[i];
    end
  end

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed bench for icache_refill_bridge: a per-cycle vector table for the best-case refill,
// then hand-written sequences for stalls, held requests, bus errors, resets and bad burst lengths.
module tb_icache_refill_bridge;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         icache_mem_req = 1'b0;
  logic [31:0]  icache_mem_addr = '0;
  logic [1:0]   icache_mem_size = 2'd2;
  logic         mem_icache_addrOK;
  logic         mem_icache_dataOK;
  logic [127:0] mem_icache_data;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         bridge_err;

  int ntests = 0;
  int nfail  = 0;

  icache_refill_bridge #(.offset_width(2)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .icache_mem_req    (icache_mem_req),
    .icache_mem_addr   (icache_mem_addr),
    .icache_mem_size   (icache_mem_size),
    .mem_icache_addrOK (mem_icache_addrOK),
    .mem_icache_dataOK (mem_icache_dataOK),
    .mem_icache_data   (mem_icache_data),
    .arvalid           (arvalid),
    .arready           (arready),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .rvalid            (rvalid),
    .rready            (rready),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .bridge_err        (bridge_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected line after nbeats beats starting from word 0, wrapping modulo N over prev contents.
  function automatic logic [127:0] exp_line(input logic [127:0] prev, input logic [31:0] base,
                                            input int nbeats);
    logic [127:0] l;
    l = prev;
    for (int b = 0; b < nbeats; b++) begin
      l[32*(b%N) +: 32] = base + 32'(b);
    end
    return l;
  endfunction

  // Starts at posedge+1 in IDLE, returns at posedge+1 of the IDLE cycle after DONE.
  task automatic refill(input logic [31:0] addr, input int ar_wait, input int nbeats,
                        input int bad_beat, input bit gap, input bit hold,
                        input logic [31:0] base, output logic [127:0] line_done);
    int beat;
    int cyc;
    logic [31:0] la;
    la = {addr[31:4], 4'h0};
    icache_mem_req  = 1'b1;
    icache_mem_addr = addr;
    @(negedge clk);
    chk("addrOK_idle", mem_icache_addrOK, 1);
    @(posedge clk); #1;
    icache_mem_req = hold;
    for (int w = 0; w <= ar_wait; w++) begin
      arready = (w == ar_wait);
      rvalid  = (w != ar_wait);
      rdata   = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("arvalid_ar", arvalid, 1);
      chk("araddr_ar", araddr, la);
      chk("rready_ar", rready, 0);
      if (hold) chk("addrOK_busy_ar", mem_icache_addrOK, 0);
      @(posedge clk); #1;
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < nbeats && cyc < 64) begin
      rvalid = gap ? (cyc % 2 == 1) : 1'b1;
      rdata  = base + 32'(beat);
      rresp  = (beat == bad_beat) ? 2'b10 : 2'b00;
      rlast  = (beat == nbeats - 1);
      @(negedge clk);
      chk("rready_r", rready, 1);
      chk("dataOK_r", mem_icache_dataOK, 0);
      chk("arvalid_r", arvalid, 0);
      if (hold) chk("addrOK_busy_r", mem_icache_addrOK, 0);
      if (bad_beat >= 0 && beat > bad_beat) chk("err_after_bad", bridge_err, 1);
      @(posedge clk); #1;
      if (rvalid) beat++;
      cyc++;
    end
    if (beat < nbeats) chk("beat_budget", 128'(beat), 128'(nbeats));
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    @(negedge clk);
    chk("dataOK_done", mem_icache_dataOK, 1);
    chk("rready_done", rready, 0);
    if (hold) chk("addrOK_busy_done", mem_icache_addrOK, 0);
    line_done = mem_icache_data;
    @(posedge clk); #1;
    if (!hold) icache_mem_req = 1'b0;
  endtask

  typedef struct {
    logic         req;
    logic [31:0]  addr;
    logic         ar_rdy;
    logic         r_vld;
    logic [31:0]  r_dat;
    logic         r_last;
    logic         e_addrok;
    logic         e_arvalid;
    logic         e_rready;
    logic         e_dataok;
    logic         chk_data;
    logic [127:0] e_data;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [127:0] line;
    logic [127:0] prev;

    vt[0] = '{1'b1, 32'h0000_1234, 1'b1, 1'b1, 32'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0};
    vt[1] = '{1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 128'h0};
    vt[2] = '{1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0};
    vt[3] = '{1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0};
    vt[4] = '{1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0};
    vt[5] = '{1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0};
    vt[6] = '{1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
              128'h000000A3_000000A2_000000A1_000000A0};
    vt[7] = '{1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              128'h000000A3_000000A2_000000A1_000000A0};

    // Reset state, with a request pending that must not be acknowledged.
    icache_mem_req = 1'b1;
    #2;
    chk("rst_addrOK", mem_icache_addrOK, 0);
    chk("rst_dataOK", mem_icache_dataOK, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_err", bridge_err, 0);
    chk("rst_data", mem_icache_data, 0);
    chk("rst_araddr", araddr, 0);
    icache_mem_req = 1'b0;
    #10;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Best-case refill, one table row per cycle starting at the request cycle.
    for (int i = 0; i < 8; i++) begin
      icache_mem_req  = vt[i].req;
      icache_mem_addr = vt[i].addr;
      arready         = vt[i].ar_rdy;
      rvalid          = vt[i].r_vld;
      rdata           = vt[i].r_dat;
      rlast           = vt[i].r_last;
      @(negedge clk);
      chk($sformatf("tbl%0d_addrOK", i), mem_icache_addrOK, vt[i].e_addrok);
      chk($sformatf("tbl%0d_arvalid", i), arvalid, vt[i].e_arvalid);
      chk($sformatf("tbl%0d_rready", i), rready, vt[i].e_rready);
      chk($sformatf("tbl%0d_dataOK", i), mem_icache_dataOK, vt[i].e_dataok);
      if (vt[i].e_arvalid) begin
        chk("tbl_araddr", araddr, 32'h0000_1230);
        chk("tbl_arlen", arlen, 8'd3);
        chk("tbl_arsize", arsize, 3'b010);
        chk("tbl_arburst", arburst, 2'b01);
      end
      if (vt[i].chk_data) chk($sformatf("tbl%0d_data", i), mem_icache_data, vt[i].e_data);
      @(posedge clk); #1;
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    chk("tbl_err", bridge_err, 0);
    prev = 128'h000000A3_000000A2_000000A1_000000A0;

    // Address stall of 5 cycles followed by a beat every other cycle.
    refill(32'h0000_ABCC, 5, 4, -1, 1'b1, 1'b0, 32'hB0, line);
    chk("stall_gap_line", line, exp_line(prev, 32'hB0, 4));
    chk("stall_gap_err", bridge_err, 0);
    @(negedge clk);
    chk("dataOK_one_cycle", mem_icache_dataOK, 0);
    @(posedge clk); #1;
    prev = line;

    // Request held high across the whole refill, then accepted again straight away.
    refill(32'h2000_0044, 0, 4, -1, 1'b0, 1'b1, 32'hC0, line);
    chk("hold1_line", line, exp_line(prev, 32'hC0, 4));
    prev = line;
    refill(32'h2000_0044, 0, 4, -1, 1'b0, 1'b0, 32'hD0, line);
    chk("hold2_line", line, exp_line(prev, 32'hD0, 4));
    chk("hold_err", bridge_err, 0);
    prev = line;

    // Error response on the second beat; the flag survives a following clean refill.
    refill(32'h0000_0300, 0, 4, 1, 1'b0, 1'b0, 32'hE0, line);
    chk("resp_err_line", line, exp_line(prev, 32'hE0, 4));
    chk("resp_err_flag", bridge_err, 1);
    prev = line;
    refill(32'h0000_0340, 0, 4, -1, 1'b0, 1'b0, 32'hF0, line);
    chk("clean_after_err_line", line, exp_line(prev, 32'hF0, 4));
    chk("err_sticky", bridge_err, 1);

    // Reset asserted in the middle of the second beat.
    icache_mem_req  = 1'b1;
    icache_mem_addr = 32'h0000_0400;
    @(posedge clk); #1;
    icache_mem_req = 1'b0;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h41;
    @(posedge clk); #1;
    rdata = 32'h42;
    icache_mem_req = 1'b1;
    #2;
    chk("pre_rst_rready", rready, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_arvalid", arvalid, 0);
    chk("midrst_rready", rready, 0);
    chk("midrst_addrOK", mem_icache_addrOK, 0);
    chk("midrst_dataOK", mem_icache_dataOK, 0);
    chk("midrst_err", bridge_err, 0);
    chk("midrst_data", mem_icache_data, 0);
    rlast = 1'b1;
    @(posedge clk); #1;
    icache_mem_req = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_dataOK", mem_icache_dataOK, 0);
      chk("post_rst_rready", rready, 0);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    refill(32'h0000_0500, 0, 4, -1, 1'b0, 1'b0, 32'h50, line);
    chk("post_rst_line", line, exp_line(128'h0, 32'h50, 4));
    chk("post_rst_err", bridge_err, 0);
    prev = line;

    // Short burst: rlast on beat 2 leaves words 2 and 3 stale.
    refill(32'h0000_0600, 0, 2, -1, 1'b0, 1'b0, 32'h60, line);
    chk("short_line", line, 128'h00000053_00000052_00000061_00000060);
    chk("short_err", bridge_err, 1);

    // Fresh reset, then an overlong burst of 6 beats that wraps onto words 0 and 1.
    #3;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    chk("rst2_err", bridge_err, 0);
    @(posedge clk); #1;
    refill(32'h0000_0700, 0, 6, -1, 1'b0, 1'b0, 32'h70, line);
    chk("long_line", line, 128'h00000073_00000072_00000075_00000074);
    chk("long_err", bridge_err, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/icache_refill_bridge.md
ICACHE_REFILL_BRIDGE -- requirements
Module: icache_refill_bridge

Interface
REQ-001 SHALL have parameter: offset_width, default 2, log2 of 32-bit words per cache line (line = 2^offset_width words, beats N = 2^offset_width).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: icache_mem_req  input  1  Icache refill request.
REQ-005 SHALL have port: icache_mem_addr  input  32  miss address (byte address).
REQ-006 SHALL have port: icache_mem_size  input  2  access size code (0-1B, 1-2B, 2-4B); accepted, not used for burst shape.
REQ-007 SHALL have port: mem_icache_addrOK  output  1  request accepted this cycle.
REQ-008 SHALL have port: mem_icache_dataOK  output  1  refill line valid this cycle.
REQ-009 SHALL have port: mem_icache_data  output  32*N  refill line; word i at bits [32i+31:32i], word 0 = line base.
REQ-010 SHALL have ports: arvalid out 1, arready in 1, araddr out 32, arlen out 8, arsize out 3, arburst out 2 -- AXI read-address channel.
REQ-011 SHALL have ports: rvalid in 1, rready out 1, rdata in 32, rresp in 2, rlast in 1 -- AXI read-data channel.
REQ-012 SHALL have port: bridge_err  output  1  sticky bus-error flag.

Function
REQ-013 SHALL implement states IDLE, AR, R, DONE.
REQ-014 IDLE: mem_icache_addrOK SHALL equal icache_mem_req combinationally; on req SHALL latch line address {addr[31:2+offset_width], zeros} and go to AR.
REQ-015 addrOK SHALL be 0 in AR, R, DONE; requests held during busy states SHALL not be accepted until back in IDLE.
REQ-016 AR: arvalid=1, araddr=latched line address, arlen=N-1, arsize=3'b010, arburst=2'b01 (INCR); on arready SHALL clear beat counter and go to R.
REQ-017 araddr/arlen/arsize/arburst SHALL stay stable while arvalid=1 and arready=0.
REQ-018 R: rready=1; each rvalid cycle SHALL write rdata to line word[counter] and increment counter (width offset_width, wraps).
REQ-019 R: rvalid&&rlast SHALL go to DONE; beats beyond N without rlast SHALL wrap and overwrite from word 0 and set bridge_err.
REQ-020 rlast before N beats SHALL go to DONE with unreceived words holding stale content and set bridge_err.
REQ-021 Any accepted beat with rresp!=0 SHALL set bridge_err; line still delivered.
REQ-022 DONE: mem_icache_dataOK=1 for exactly one cycle with full line on mem_icache_data; next state IDLE.
REQ-023 mem_icache_data SHALL hold last delivered line until the next refill's first beat overwrites it.
REQ-024 rready SHALL be 0 outside R; rvalid outside R SHALL be ignored.
REQ-025 Best-case latency (arready and rvalid always high): req at cycle 0, addrOK cycle 0, arvalid cycle 1, beats cycles 2..N+1, dataOK cycle N+2.
REQ-026 A new request SHALL be acceptable in the IDLE cycle immediately after DONE (no extra bubble).
REQ-027 bridge_err SHALL clear only on reset.

Reset
REQ-028 rstn low SHALL immediately force state IDLE and arvalid, rready, mem_icache_addrOK, mem_icache_dataOK, bridge_err to 0, counter and latched address to 0, line buffer to 0.
REQ-029 Reset mid-burst SHALL abandon the transaction without delivering dataOK; the bus side is reset together with the bridge.

Verification
REQ-030 offset_width=2, req addr 0x0000_1234, arready/rvalid always 1, rdata 0xA0..0xA3 with rlast on 4th -> araddr 0x0000_1230, arlen 3, dataOK cycle 6, data {0xA3,0xA2,0xA1,0xA0}.
REQ-031 arready held 0 for 5 cycles -> arvalid and araddr stable throughout, no rready until handshake.
REQ-032 rvalid toggling every other cycle -> 4 words captured in order, dataOK exactly one cycle after rlast beat.
REQ-033 req held high during R and DONE -> addrOK 0 there, then 1 in following IDLE cycle, second refill correct.
REQ-034 rresp=2'b10 on beat 2 -> bridge_err 1 after that beat, line delivered, flag persists through next clean refill.
REQ-035 rstn pulsed low during beat 2 -> all outputs 0 asynchronously, no dataOK, next req after release handled normally.
